// File: rtl/imm_extend_queue_if.sv
// ---------------------------------------------------------------------------
// imm_extend_queue_if
// Handshake bundle between decode (producer), the immediate-extension queue
// and execute (consumer).
//   in_valid/in_ready   : push handshake, decode -> queue
//   in_imm/in_mode      : raw immediate field and 2-bit extension mode
//   out_valid/out_ready : pop handshake, queue -> execute
//   out_imm/out_mode    : extended head operand and its mode (0 when empty)
// master : drives the decode and execute sides (bench or pipeline glue)
// slave  : the queue itself
// ---------------------------------------------------------------------------
interface imm_extend_queue_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_imm;
   logic [1:0]       out_mode;

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_imm, out_mode
   );

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_imm, out_mode
   );
endinterface

// File: rtl/imm_extend_queue.sv
// ---------------------------------------------------------------------------
// imm_extend_queue
// Immediate-extension unit followed by a 2-entry FIFO with valid/ready on
// both sides so decode and execute can stall independently.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears count, pointers and entries
//   q     : imm_extend_queue_if.slave (push side in_*, pop side out_*)
// Extension modes: 00 sign, 01 zero, 10 upper placement, 11 branch offset.
// Build option: IMMEXT_BRSHIFT_EN -- when defined, mode 11 is sign-extend
// then shift left by 2; when undefined, mode 11 extends like mode 00 (the
// stored mode still reads back as 11).
// ---------------------------------------------------------------------------
module imm_extend_queue #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input logic               clk,
   input logic               reset,
   imm_extend_queue_if.slave q
);
   localparam int E = OUT_W - IN_W;

   // Occupancy doubles as the FSM state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [OUT_W-1:0] val_q  [2];
   logic [1:0]       mode_q [2];

   logic             push, pop;
   logic [OUT_W-1:0] sext, ext;

   // ---------------- extension datapath ----------------
   always_comb begin
      sext = {{E{q.in_imm[IN_W-1]}}, q.in_imm};
      ext  = sext;
      case (q.in_mode)
         2'b01:   ext = {{E{1'b0}}, q.in_imm};
         2'b10:   ext = {q.in_imm, {E{1'b0}}};
`ifdef IMMEXT_BRSHIFT_EN
         2'b11:   ext = sext << 2;
`else
         2'b11:   ext = sext;
`endif
         default: ext = sext;
      endcase
   end

   // ---------------- handshakes ----------------
   // in_ready looks at occupancy only, so a pop in FULL cannot open the
   // door for a push on the same edge (no out_ready -> in_ready path).
   assign q.in_ready  = (state_q != FULL);
   assign q.out_valid = (state_q != EMPTY);
   assign q.out_imm   = (state_q == EMPTY) ? '0    : val_q[rd_ptr_q];
   assign q.out_mode  = (state_q == EMPTY) ? 2'b00 : mode_q[rd_ptr_q];

   assign push = q.in_valid  && q.in_ready;
   assign pop  = q.out_valid && q.out_ready;

   // ---------------- next state ----------------
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)      state_d = FULL;
            else if (pop && !push) state_d = EMPTY;
         end
         FULL:  if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // ---------------- state and storage ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= EMPTY;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         val_q[0]  <= '0;
         val_q[1]  <= '0;
         mode_q[0] <= 2'b00;
         mode_q[1] <= 2'b00;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) begin
            val_q[wr_ptr_q]  <= ext;
            mode_q[wr_ptr_q] <= q.in_mode;
         end
      end
   end
endmodule

// File: tb/tb_imm_extend_queue.sv
// Scoreboard bench: drivers push expected {mode,value} into a queue when a
// push is accepted; monitors pop and compare whenever a pop handshake occurs.
module tb_imm_extend_queue;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

`ifdef IMMEXT_BRSHIFT_EN
   localparam logic [31:0] BR16 = 32'hFFFE0004;
   localparam logic [31:0] BR12 = 32'hFFFFE000;
`else
   localparam logic [31:0] BR16 = 32'hFFFF8001;
   localparam logic [31:0] BR12 = 32'hFFFFF800;
`endif

   imm_extend_queue_if #(.IN_W(16), .OUT_W(32)) a ();
   imm_extend_queue_if #(.IN_W(12), .OUT_W(32)) b ();

   imm_extend_queue #(.IN_W(16), .OUT_W(32)) dut_a (.clk(clk), .reset(reset), .q(a));
   imm_extend_queue #(.IN_W(12), .OUT_W(32)) dut_b (.clk(clk), .reset(reset), .q(b));

   logic [33:0] sba [$];
   logic [33:0] sbb [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!reset && a.out_valid && a.out_ready) begin
         logic [33:0] e;
         checks++;
         if (sba.size() == 0) begin
            errors++;
            $display("FAIL mon_a_unexpected: got %h expected nothing", {a.out_mode, a.out_imm});
         end else begin
            e = sba.pop_front();
            if ({a.out_mode, a.out_imm} !== e) begin
               errors++;
               $display("FAIL mon_a: got %h expected %h", {a.out_mode, a.out_imm}, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && b.out_valid && b.out_ready) begin
         logic [33:0] e;
         checks++;
         if (sbb.size() == 0) begin
            errors++;
            $display("FAIL mon_b_unexpected: got %h expected nothing", {b.out_mode, b.out_imm});
         end else begin
            e = sbb.pop_front();
            if ({b.out_mode, b.out_imm} !== e) begin
               errors++;
               $display("FAIL mon_b: got %h expected %h", {b.out_mode, b.out_imm}, e);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic push_a(input logic [15:0] imm, input logic [1:0] md,
                         input logic [31:0] ev, input bit track, output int waits);
      waits = 0;
      a.in_valid = 1'b1; a.in_imm = imm; a.in_mode = md;
      @(negedge clk);
      while (!a.in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!a.in_ready) begin
         checks++; errors++;
         $display("FAIL push_a_timeout: got in_ready=0 expected 1");
      end else if (track) sba.push_back({md, ev});
      @(posedge clk); #1;
      a.in_valid = 1'b0;
   endtask

   task automatic push_b(input logic [11:0] imm, input logic [1:0] md, input logic [31:0] ev);
      int waits = 0;
      b.in_valid = 1'b1; b.in_imm = imm; b.in_mode = md;
      @(negedge clk);
      while (!b.in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!b.in_ready) begin
         checks++; errors++;
         $display("FAIL push_b_timeout: got in_ready=0 expected 1");
      end else sbb.push_back({md, ev});
      @(posedge clk); #1;
      b.in_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] v1 [4] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001};
   logic [31:0] e1 [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, BR16};

   initial begin
      int w;
      reset = 1'b1;
      a.in_valid = 1'b0; a.in_imm = '0; a.in_mode = 2'b00; a.out_ready = 1'b0;
      b.in_valid = 1'b0; b.in_imm = '0; b.in_mode = 2'b00; b.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("rst_in_ready",  a.in_ready,  1);
      chk("rst_out_valid", a.out_valid, 0);
      chk("rst_out_imm",   a.out_imm,   0);
      chk("rst_out_mode",  a.out_mode,  0);

      // four modes on consecutive cycles
      @(posedge clk); #1;
      a.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_a(v1[i], 2'(i), e1[i], 1'b1, w);

      // latency: visible the cycle after push
      push_a(16'h7FFF, 2'b00, 32'h00007FFF, 1'b1, w);
      @(negedge clk);
      chk("lat_valid", a.out_valid, 1);
      chk("lat_imm",   a.out_imm,   32'h00007FFF);
      @(posedge clk); #1;
      push_a(16'hFFFF, 2'b01, 32'h0000FFFF, 1'b1, w);
      @(posedge clk); #1;

      // back-pressure: fill, hold third, then drain
      a.out_ready = 1'b0;
      push_a(16'h0001, 2'b00, 32'h1, 1'b1, w);
      push_a(16'h0002, 2'b00, 32'h2, 1'b1, w);
      a.in_valid = 1'b1; a.in_imm = 16'h0003; a.in_mode = 2'b00;
      @(negedge clk);
      chk("full_in_ready", a.in_ready, 0);
      @(negedge clk);
      chk("full_hold_rdy",  a.in_ready, 0);
      chk("full_head_imm",  a.out_imm,  32'h1);
      @(posedge clk); #1;
      a.out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_rdy", a.in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rdy_after_pop", a.in_ready, 1);
      sba.push_back({2'b00, 32'h3});
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      repeat (3) @(posedge clk); #1;

      // streaming in ONE state
      for (int i = 0; i < 20; i++) begin
         push_a(16'(16'h0100 + i), 2'b01, 32'(32'h100 + i), 1'b1, w);
         chk("stream_no_stall", w, 0);
      end
      @(negedge clk);
      chk("stream_last_valid", a.out_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream_drained", a.out_valid, 0);

      // reset while FULL discards entries
      @(posedge clk); #1;
      a.out_ready = 1'b0;
      push_a(16'hDEAD, 2'b00, 32'h0, 1'b0, w);
      push_a(16'hBEEF, 2'b01, 32'h0, 1'b0, w);
      @(negedge clk);
      chk("pre_rst_full", a.in_ready, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", a.out_valid, 0);
      chk("mid_rst_imm",   a.out_imm,   0);
      chk("mid_rst_mode",  a.out_mode,  0);
      chk("mid_rst_ready", a.in_ready,  1);
      @(posedge clk); #1;
      a.out_ready = 1'b1;
      push_a(16'h1234, 2'b10, 32'h12340000, 1'b1, w);

      // narrow instance
      push_b(12'h800, 2'b00, 32'hFFFFF800);
      push_b(12'h800, 2'b10, 32'h80000000);
      push_b(12'h800, 2'b01, 32'h00000800);
      push_b(12'h800, 2'b11, BR12);

      // drain, bounded
      for (int i = 0; i < 100 && (sba.size() != 0 || sbb.size() != 0); i++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("sb_a_empty", sba.size(), 0);
      chk("sb_b_empty", sbb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
